sha256_digest_serializer: RTL and testbench

//  Downstream of the SHA-256 core. Captures one 256-bit digest via the core's v/yumi

---
 rtl/sha256_pkg.sv | 19 +
 rtl/sha256_digest_serializer_if.sv | 17 +
 rtl/sha256_digest_serializer.sv | 79 +++++++
 tb/tb_sha256_digest_serializer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Constants and types shared between the SHA-256 core and its digest serializer.
package sha256_pkg;

    localparam int unsigned SHA256_DIGEST_W = 256;

    localparam logic [31:0] H0 = 32'h6a09e667;
    localparam logic [31:0] H1 = 32'hbb67ae85;
    localparam logic [31:0] H2 = 32'h3c6ef372;
    localparam logic [31:0] H3 = 32'ha54ff53a;
    localparam logic [31:0] H4 = 32'h510e527f;
    localparam logic [31:0] H5 = 32'h9b05688c;
    localparam logic [31:0] H6 = 32'h1f83d9ab;
    localparam logic [31:0] H7 = 32'h5be0cd19;

    localparam logic [SHA256_DIGEST_W-1:0] msg_init = {H0, H1, H2, H3, H4, H5, H6, H7};

    typedef enum logic {eIdle, eSend} ser_state_e;

endpackage

// File: rtl/sha256_digest_serializer_if.sv
// Core-side v/yumi digest handshake plus the word-wide valid/ready output link.
interface sha256_digest_serializer_if
    import sha256_pkg::*;
#(
    parameter int unsigned WORD_W = 32
);
    logic                       v_i;
    logic [SHA256_DIGEST_W-1:0] digest_i;
    logic                       yumi_o;
    logic                       v_o;
    logic                       ready_i;
    logic [WORD_W-1:0]          data_o;
    logic                       last_o;

    modport master (output v_i, digest_i, ready_i, input yumi_o, v_o, data_o, last_o);
    modport slave  (input v_i, digest_i, ready_i, output yumi_o, v_o, data_o, last_o);
endinterface

// File: rtl/sha256_digest_serializer.sv
// Buffers one SHA-256 digest and emits it as NUM_WORDS beats; the next digest may be
// captured on the last beat so back-to-back digests stream with no bubble.
module sha256_digest_serializer
    import sha256_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter bit          MSW_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    sha256_digest_serializer_if.slave bus,
    output logic [CNT_W-1:0]         digest_cnt_o
);
    localparam int unsigned NUM_WORDS = SHA256_DIGEST_W / WORD_W;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    if (SHA256_DIGEST_W % WORD_W != 0) begin : g_bad_word_w
        $error("sha256_digest_serializer: WORD_W must divide 256");
    end

    ser_state_e                          state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                send, last_word, xfer, yumi;
    logic [IDX_W-1:0]                    sel;

    always_comb begin
        send      = (state_q == eSend);
        last_word = send && (idx_q == LAST_IDX);
        xfer      = send && bus.ready_i;
        // In eSend a new digest is only taken as the final beat leaves.
        yumi      = en_i && bus.v_i && (!send || (xfer && last_word));
        sel       = MSW_FIRST ? (LAST_IDX - idx_q) : idx_q;

        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            if (last_word) begin
                cnt_d   = cnt_q + 1'b1;
                idx_d   = '0;
                state_d = eIdle;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (yumi) begin
            buf_d   = bus.digest_i;
            idx_d   = '0;
            state_d = eSend;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eIdle;
            idx_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.yumi_o   = yumi;
    assign bus.v_o      = send;
    assign bus.data_o   = send ? buf_q[sel] : '0;
    assign bus.last_o   = last_word;
    assign digest_cnt_o = cnt_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Four serializer builds driven in lockstep and compared against a queue-based model.
module tb_sha256_digest_serializer;
    import sha256_pkg::*;

    localparam int NI = 4;
    typedef logic [146:0] obs_t;    // {yumi, v, last, data[127:0], cnt[15:0]}

    logic clk;
    logic rst, en, vin, rdy;
    logic [255:0] dig;
    logic [255:0] D;
    logic [31:0]  DW [8];
    int total = 0;
    int bad   = 0;

    logic [127:0]  mq   [NI][$];
    int unsigned   mcnt [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sha256_digest_serializer_if #(.WORD_W(32)) if0 ();
    sha256_digest_serializer_if #(.WORD_W(32)) if1 ();
    sha256_digest_serializer_if #(.WORD_W(64)) if2 ();
    sha256_digest_serializer_if #(.WORD_W(32)) if3 ();
    logic [15:0] cnt0, cnt1, cnt2;
    logic [3:0]  cnt3;

    assign if0.v_i = vin;  assign if0.digest_i = dig;  assign if0.ready_i = rdy;
    assign if1.v_i = vin;  assign if1.digest_i = dig;  assign if1.ready_i = rdy;
    assign if2.v_i = vin;  assign if2.digest_i = dig;  assign if2.ready_i = rdy;
    assign if3.v_i = vin;  assign if3.digest_i = dig;  assign if3.ready_i = rdy;

    sha256_digest_serializer #(.WORD_W(32), .MSW_FIRST(1'b1), .CNT_W(16)) dut0 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .bus(if0.slave), .digest_cnt_o(cnt0));
    sha256_digest_serializer #(.WORD_W(32), .MSW_FIRST(1'b0), .CNT_W(16)) dut1 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .bus(if1.slave), .digest_cnt_o(cnt1));
    sha256_digest_serializer #(.WORD_W(64), .MSW_FIRST(1'b1), .CNT_W(16)) dut2 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .bus(if2.slave), .digest_cnt_o(cnt2));
    sha256_digest_serializer #(.WORD_W(32), .MSW_FIRST(1'b1), .CNT_W(4)) dut3 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .bus(if3.slave), .digest_cnt_o(cnt3));

    obs_t obs [NI];
    assign obs[0] = {if0.yumi_o, if0.v_o, if0.last_o, if0.v_o ? 128'(if0.data_o) : 128'd0, cnt0};
    assign obs[1] = {if1.yumi_o, if1.v_o, if1.last_o, if1.v_o ? 128'(if1.data_o) : 128'd0, cnt1};
    assign obs[2] = {if2.yumi_o, if2.v_o, if2.last_o, if2.v_o ? 128'(if2.data_o) : 128'd0, cnt2};
    assign obs[3] = {if3.yumi_o, if3.v_o, if3.last_o, if3.v_o ? 128'(if3.data_o) : 128'd0, 12'd0, cnt3};

    function automatic int ww_of(int i);
        return (i == 2) ? 64 : 32;
    endfunction

    function automatic bit msw_of(int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic int cw_of(int i);
        return (i == 3) ? 4 : 16;
    endfunction

    // Beat k of digest d as it should appear on the link of build i.
    function automatic logic [127:0] word_of(int i, logic [255:0] d, int k);
        int w, nw, idx;
        logic [255:0] t;
        logic [127:0] m;
        w   = ww_of(i);
        nw  = 256 / w;
        idx = msw_of(i) ? (nw - 1 - k) : k;
        t   = d >> (idx * w);
        m   = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        return t[127:0] & m;
    endfunction

    function automatic obs_t model_exp(int i);
        logic y, v, l;
        logic [127:0] dat;
        logic [15:0]  c;
        v   = (mq[i].size() != 0);
        l   = (mq[i].size() == 1);
        dat = v ? mq[i][0] : 128'd0;
        y   = en && vin && (!v || (rdy && l));
        c   = 16'(mcnt[i] & ((32'd1 << cw_of(i)) - 32'd1));
        return {y, v, l, dat, c};
    endfunction

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            obs_t e;
            e = model_exp(i);
            if (rst) begin
                mq[i].delete();
                mcnt[i] = 0;
            end else begin
                if (e[145] && rdy) begin
                    void'(mq[i].pop_front());
                    if (e[144]) mcnt[i]++;
                end
                if (e[146])
                    for (int k = 0; k < 256 / ww_of(i); k++) mq[i].push_back(word_of(i, dig, k));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drain();
        rst = 1'b0; en = 1'b0; vin = 1'b0; rdy = 1'b1;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; vin = 1'b0; rdy = 1'b0; dig = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (obs[i] !== '0) begin
                bad++;
                $display("FAIL reset_state dut%0d got=%h exp=0", i, obs[i]);
            end
        end
        total++;
        if (if0.data_o !== 32'd0 || if2.data_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h exp=0", if0.data_o, if2.data_o);
        end
        step();
    endtask

    task automatic test_abc();
        en = 1'b1; vin = 1'b1; dig = D; rdy = 1'b1;
        @(negedge clk);
        total++;
        if (if0.yumi_o !== 1'b1) begin
            bad++;
            $display("FAIL abc_yumi got=%b exp=1", if0.yumi_o);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (obs[i] !== model_exp(i)) begin
                bad++;
                $display("FAIL abc_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
            end
        end
        step();
        vin = 1'b0;
        dig = ~D;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (if0.data_o !== DW[k] || if0.last_o !== 1'(k == 7)) begin
                bad++;
                $display("FAIL abc_msw beat=%0d got=%h/%b exp=%h/%b", k, if0.data_o, if0.last_o, DW[k], k == 7);
            end
            total++;
            if (if1.data_o !== DW[7-k] || if1.last_o !== 1'(k == 7)) begin
                bad++;
                $display("FAIL abc_lsw beat=%0d got=%h/%b exp=%h/%b", k, if1.data_o, if1.last_o, DW[7-k], k == 7);
            end
            if (k < 4) begin
                total++;
                if (if2.data_o !== {DW[2*k], DW[2*k+1]} || if2.last_o !== 1'(k == 3)) begin
                    bad++;
                    $display("FAIL abc_w64 beat=%0d got=%h/%b exp=%h%h/%b", k, if2.data_o, if2.last_o, DW[2*k], DW[2*k+1], k == 3);
                end
            end
            for (int i = 0; i < NI; i++) begin
                total++;
                if (obs[i] !== model_exp(i)) begin
                    bad++;
                    $display("FAIL abc_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
                end
            end
            step();
        end
        @(negedge clk);
        total++;
        if (cnt0 !== 16'd1 || if0.v_o !== 1'b0 || cnt2 !== 16'd1) begin
            bad++;
            $display("FAIL abc_cnt got=%0d/%0d v=%b exp=1/1 v=0", cnt0, cnt2, if0.v_o);
        end
        step();
    endtask

    task automatic test_stall();
        logic [31:0] got_q [$];
        logic [31:0] prev_d;
        logic        prev_hold;
        prev_hold = 1'b0;
        prev_d    = '0;
        en = 1'b1; vin = 1'b1; dig = D;
        for (int c = 0; c < 24; c++) begin
            rdy = (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
            if (prev_hold) begin
                total++;
                if (if0.data_o !== prev_d || if0.v_o !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/1", c, if0.data_o, if0.v_o, prev_d);
                end
            end
            if (if0.v_o && rdy) got_q.push_back(if0.data_o);
            prev_hold = if0.v_o && !rdy;
            prev_d    = if0.data_o;
            for (int i = 0; i < NI; i++) begin
                total++;
                if (obs[i] !== model_exp(i)) begin
                    bad++;
                    $display("FAIL stall_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
                end
            end
            step();
            vin = 1'b0;
        end
        total++;
        if (got_q.size() != 8) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=8", got_q.size());
        end
        for (int k = 0; k < 8 && k < int'(got_q.size()); k++) begin
            total++;
            if (got_q[k] !== DW[k]) begin
                bad++;
                $display("FAIL stall_order beat=%0d got=%h exp=%h", k, got_q[k], DW[k]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        en = 1'b1; vin = 1'b1; dig = D; rdy = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 16) begin
                total++;
                if (if0.v_o !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_bubble cyc=%0d got=%b exp=1", c, if0.v_o);
                end
            end
            if (c >= 1 && c <= 7) begin
                total++;
                if (if0.yumi_o !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_early_yumi cyc=%0d got=%b exp=0", c, if0.yumi_o);
                end
            end
            if (c == 8) begin
                total++;
                if (if0.yumi_o !== 1'b1 || if0.last_o !== 1'b1 || if0.data_o !== DW[7]) begin
                    bad++;
                    $display("FAIL b2b_overlap got=%b/%b/%h exp=1/1/%h", if0.yumi_o, if0.last_o, if0.data_o, DW[7]);
                end
            end
            if (c == 9) begin
                total++;
                if (if0.data_o !== ~DW[0]) begin
                    bad++;
                    $display("FAIL b2b_first got=%h exp=%h", if0.data_o, ~DW[0]);
                end
            end
            for (int i = 0; i < NI; i++) begin
                total++;
                if (obs[i] !== model_exp(i)) begin
                    bad++;
                    $display("FAIL b2b_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
                end
            end
            step();
            if (c == 0) dig = ~D;
            if (c == 8) vin = 1'b0;
        end
        drain();
    endtask

    task automatic test_enable();
        int n;
        en = 1'b0; vin = 1'b1; dig = D; rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (if0.yumi_o !== 1'b0 || if0.v_o !== 1'b0) begin
                bad++;
                $display("FAIL en_block cyc=%0d got=%b/%b exp=0/0", c, if0.yumi_o, if0.v_o);
            end
            for (int i = 0; i < NI; i++) begin
                total++;
                if (obs[i] !== model_exp(i)) begin
                    bad++;
                    $display("FAIL en_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
                end
            end
            step();
        end
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (obs[i] !== model_exp(i)) begin
                bad++;
                $display("FAIL en_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
            end
        end
        step();
        en = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if0.v_o && rdy) n++;
            total++;
            if (if0.yumi_o !== 1'b0) begin
                bad++;
                $display("FAIL en_drain_yumi cyc=%0d got=%b exp=0", c, if0.yumi_o);
            end
            for (int i = 0; i < NI; i++) begin
                total++;
                if (obs[i] !== model_exp(i)) begin
                    bad++;
                    $display("FAIL en_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
                end
            end
            step();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL en_drain_count got=%0d exp=8", n);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        en = 1'b1; vin = 1'b1; dig = D; rdy = 1'b1;
        @(negedge clk);
        step();
        vin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (if0.data_o !== DW[k]) begin
                bad++;
                $display("FAIL rstmid_pre beat=%0d got=%h exp=%h", k, if0.data_o, DW[k]);
            end
            step();
        end
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (obs[i] !== model_exp(i)) begin
                bad++;
                $display("FAIL rstmid_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
            end
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (if0.v_o !== 1'b0 || cnt0 !== 16'd0 || cnt3 !== 4'd0 || if2.v_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear got v=%b/%b cnt=%0d/%0d exp v=0/0 cnt=0/0", if0.v_o, if2.v_o, cnt0, cnt3);
        end
        step();
        en = 1'b1; vin = 1'b1; dig = ~D;
        @(negedge clk);
        step();
        vin = 1'b0;
        @(negedge clk);
        total++;
        if (if0.v_o !== 1'b1 || if0.data_o !== ~DW[0]) begin
            bad++;
            $display("FAIL rstmid_fresh got=%b/%h exp=1/%h", if0.v_o, if0.data_o, ~DW[0]);
        end
        step();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 99) < 85);
            vin = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 99) < 60);
            for (int b = 0; b < 8; b++) dig[b*32 +: 32] = $urandom();
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                total++;
                if (obs[i] !== model_exp(i)) begin
                    bad++;
                    $display("FAIL rand_model cyc=%0d dut%0d got=%h exp=%h", c, i, obs[i], model_exp(i));
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_wrap();
        bit seen15, done;
        seen15 = 1'b0;
        done   = 1'b0;
        rst = 1'b1; en = 1'b0; vin = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; vin = 1'b1; rdy = 1'b1;
        for (int c = 0; c < 150 && !done; c++) begin
            for (int b = 0; b < 8; b++) dig[b*32 +: 32] = $urandom();
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                total++;
                if (obs[i] !== model_exp(i)) begin
                    bad++;
                    $display("FAIL wrap_model dut%0d got=%h exp=%h", i, obs[i], model_exp(i));
                end
            end
            if (cnt0 == 16'd15 && !seen15) begin
                seen15 = 1'b1;
                total++;
                if (cnt3 !== 4'd15) begin
                    bad++;
                    $display("FAIL wrap_15 got=%0d exp=15", cnt3);
                end
            end
            if (cnt0 == 16'd16) begin
                done = 1'b1;
                total++;
                if (cnt3 !== 4'd0) begin
                    bad++;
                    $display("FAIL wrap_0 got=%0d exp=0", cnt3);
                end
            end
            step();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wrap_timeout got=cnt %0d exp=cnt 16 within 150 cycles", cnt0);
        end
        drain();
    endtask

    initial begin
        DW = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        D  = {DW[0], DW[1], DW[2], DW[3], DW[4], DW[5], DW[6], DW[7]};
        for (int i = 0; i < NI; i++) mcnt[i] = 0;
        rst = 1'b1; en = 1'b0; vin = 1'b0; rdy = 1'b0; dig = '0;
        test_reset();
        test_abc();
        test_stall();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
